ifetch_unit: RTL and testbench

//  Instruction fetch engine for mycpu: owns the program counter, reads one DATA_W

---
 rtl/ifetch_unit.sv | 122 ++++++++++++
 tb/tb_ifetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch engine: owns the PC, fetches one word per request over req/ack, pulses IR load.
// Optional fetch timeout enabled by defining IFETCH_TIMEOUT_EN.
module ifetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req_in,
  input  logic              jmp_in,
  input  logic [ADDR_W-1:0] jmp_addr_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              il_out,
  output logic [DATA_W-1:0] ins_out,
  output logic              fetch_done_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              err_out
);

  // Memory handshake: mem_req_out rises in REQ and holds, with mem_addr_out stable,
  // until the cycle mem_ack_in=1; the read data is captured on that same edge.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  if (TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("ifetch_unit: TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ins;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic              timeout_hit;

`ifdef IFETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          err;

  assign timeout_hit = (state == ST_REQ) && !mem_ack_in && (tcnt == TW'(TIMEOUT_CYC - 1));

  // Counts REQ cycles without ack; any exit from REQ returns it to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (state == ST_REQ && !mem_ack_in && !timeout_hit)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
      if (timeout_hit)
        err <= 1'b1;
    end
  end

  assign err_out = err;
`else
  assign timeout_hit = 1'b0;
  assign err_out     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      ins        <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A same-cycle jump lands before the fetch starts, so REQ reads the target.
          if (jmp_in)
            pc <= jmp_addr_in;
          if (fetch_req_in)
            state <= ST_REQ;
        end
        ST_REQ: begin
          if (jmp_in) begin
            pend_valid <= 1'b1;
            pend_addr  <= jmp_addr_in;
          end
          if (mem_ack_in) begin
            ins   <= mem_rdata_in;
            pc    <= pc + 1'b1;
            state <= ST_LOAD;
          end else if (timeout_hit) begin
            state <= ST_ERR;
          end
        end
        ST_LOAD, ST_ERR: begin
          // Deferred jump overrides the increment; a jump in this very cycle is the latest.
          if (jmp_in)
            pc <= jmp_addr_in;
          else if (pend_valid)
            pc <= pend_addr;
          pend_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_out    = (state == ST_REQ);
  assign mem_addr_out   = pc;
  assign il_out         = (state == ST_LOAD);
  assign fetch_done_out = (state == ST_LOAD) || (state == ST_ERR);
  assign ins_out        = ins;
  assign pc_out         = pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed steps plus randomized fetches against a PC/IR model.
// Exercises the timeout path when IFETCH_TIMEOUT_EN is defined.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_in;
  logic        jmp_in;
  logic [7:0]  jmp_addr_in;
  logic        mem_req_out;
  logic [7:0]  mem_addr_out;
  logic        mem_ack_in;
  logic [15:0] mem_rdata_in;
  logic        il_out;
  logic [15:0] ins_out;
  logic        fetch_done_out;
  logic [7:0]  pc_out;
  logic        err_out;

  int checks   = 0;
  int failures = 0;

  // Reference model state: architectural PC, IR contents, sticky error.
  int          exp_pc;
  logic [15:0] exp_ins;
  logic        exp_err;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_req_in   (fetch_req_in),
    .jmp_in         (jmp_in),
    .jmp_addr_in    (jmp_addr_in),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_ack_in     (mem_ack_in),
    .mem_rdata_in   (mem_rdata_in),
    .il_out         (il_out),
    .ins_out        (ins_out),
    .fetch_done_out (fetch_done_out),
    .pc_out         (pc_out),
    .err_out        (err_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},  32'(mem_req_out),    32'd0);
    check({tag, "_il"},   32'(il_out),         32'd0);
    check({tag, "_done"}, 32'(fetch_done_out), 32'd0);
    check({tag, "_pc"},   32'(pc_out),         32'(exp_pc));
    check({tag, "_addr"}, 32'(mem_addr_out),   32'(exp_pc));
    check({tag, "_ins"},  32'(ins_out),        32'(exp_ins));
    check({tag, "_err"},  32'(err_out),        32'(exp_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_req_in = 1'b0; jmp_in = 1'b0; jmp_addr_in = 8'h00;
    mem_ack_in = 1'b0; mem_rdata_in = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = 0; exp_ins = 16'h0000; exp_err = 1'b0;
    check_idle("reset");
  endtask

  // One fetch starting from IDLE at a negedge. waits = REQ cycles before the ack cycle.
  // mid_cyc: index of REQ/LOAD cycle (0..waits+1) to jump in, -1 for none.
  task automatic run_fetch(input int waits, input logic [15:0] data, input bit jmp_now,
                           input logic [7:0] now_addr, input int mid_cyc,
                           input logic [7:0] mid_addr, input bit rnd_jmp);
    int pend = -1;
    if (jmp_now) begin
      jmp_in = 1'b1; jmp_addr_in = now_addr; exp_pc = now_addr;
    end
    fetch_req_in = 1'b1;
    @(negedge clk);
    fetch_req_in = 1'b0; jmp_in = 1'b0;
    for (int c = 0; c <= waits + 1; c++) begin
      if (c <= waits) begin
        check("req_hold",  32'(mem_req_out),    32'd1);
        check("req_addr",  32'(mem_addr_out),   32'(exp_pc));
        check("req_il",    32'(il_out),         32'd0);
        check("req_done",  32'(fetch_done_out), 32'd0);
        check("req_err",   32'(err_out),        32'(exp_err));
      end else begin
        exp_ins = data;
        exp_pc  = (exp_pc + 1) % 256;
        check("load_il",   32'(il_out),         32'd1);
        check("load_done", 32'(fetch_done_out), 32'd1);
        check("load_ins",  32'(ins_out),        32'(exp_ins));
        check("load_pc",   32'(pc_out),         32'(exp_pc));
        check("load_req",  32'(mem_req_out),    32'd0);
      end
      mem_ack_in   = (c == waits) ? 1'b1 : ((c > waits) ? 1'($urandom_range(0, 1)) : 1'b0);
      mem_rdata_in = (c == waits) ? data : 16'($urandom);
      fetch_req_in = 1'($urandom_range(0, 1));
      jmp_in = 1'b0;
      if (c == mid_cyc || (rnd_jmp && $urandom_range(0, 3) == 0)) begin
        jmp_in      = 1'b1;
        jmp_addr_in = (c == mid_cyc) ? mid_addr : 8'($urandom);
        pend        = jmp_addr_in;
      end
      @(negedge clk);
    end
    mem_ack_in = 1'b0; jmp_in = 1'b0; fetch_req_in = 1'b0;
    if (pend >= 0) exp_pc = pend;
    check_idle("post_fetch");
  endtask

  // IDLE cycles with noise on ack/data: nothing may change.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack_in   = 1'($urandom_range(0, 1));
      mem_rdata_in = 16'($urandom);
      fetch_req_in = 1'b0; jmp_in = 1'b0;
      @(negedge clk);
      check_idle("idle_gap");
    end
    mem_ack_in = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Basic fetch, ack on first REQ cycle.
    run_fetch(0, 16'hA5C3, 1'b0, 8'h00, -1, 8'h00, 1'b0);
    idle_gap(2);

    // Three wait states.
    run_fetch(3, 16'h1234, 1'b0, 8'h00, -1, 8'h00, 1'b0);

    // PC wrap from 8'hFF.
    run_fetch(0, 16'hBEEF, 1'b1, 8'hFF, -1, 8'h00, 1'b0);
    check("wrap_pc", 32'(pc_out), 32'h00);

    // Jump with fetch in same IDLE cycle, then a jump during REQ.
    run_fetch(0, 16'h0F0F, 1'b1, 8'h40, -1, 8'h00, 1'b0);
    check("jmp_idle_pc", 32'(pc_out), 32'h41);
    run_fetch(2, 16'h7777, 1'b0, 8'h00, 1, 8'h20, 1'b0);
    check("jmp_req_pc", 32'(pc_out), 32'h20);

    // Jump during LOAD, and two jumps in one fetch (last wins).
    run_fetch(1, 16'h5A5A, 1'b0, 8'h00, 2, 8'h90, 1'b0);
    run_fetch(3, 16'h6B6B, 1'b0, 8'h00, 3, 8'h33, 1'b1);

    // Reset asserted in REQ, with a jump arriving the same cycle.
    fetch_req_in = 1'b1;
    @(negedge clk);
    fetch_req_in = 1'b0;
    check("rst_req_pre", 32'(mem_req_out), 32'd1);
    rst = 1'b1; jmp_in = 1'b1; jmp_addr_in = 8'h77;
    @(negedge clk);
    rst = 1'b0; jmp_in = 1'b0;
    exp_pc = 0; exp_ins = 16'h0000; exp_err = 1'b0;
    check_idle("rst_in_req");
    run_fetch(0, 16'hC001, 1'b0, 8'h00, -1, 8'h00, 1'b0);

`ifdef IFETCH_TIMEOUT_EN
    // Ack on the last allowed REQ cycle wins; counter must clear between fetches.
    run_fetch(14, 16'hD00D, 1'b0, 8'h00, -1, 8'h00, 1'b0);
    run_fetch(10, 16'hD00E, 1'b0, 8'h00, -1, 8'h00, 1'b0);
    run_fetch(10, 16'hD00F, 1'b0, 8'h00, -1, 8'h00, 1'b0);
    // No ack at all: timeout.
    fetch_req_in = 1'b1;
    @(negedge clk);
    fetch_req_in = 1'b0;
    for (int c = 0; c < 15; c++) begin
      check("to_req", 32'(mem_req_out), 32'd1);
      check("to_done_early", 32'(fetch_done_out), 32'd0);
      @(negedge clk);
    end
    exp_err = 1'b1;
    check("to_req_drop", 32'(mem_req_out),    32'd0);
    check("to_done",     32'(fetch_done_out), 32'd1);
    check("to_il",       32'(il_out),         32'd0);
    check("to_err",      32'(err_out),        32'd1);
    check("to_pc",       32'(pc_out),         32'(exp_pc));
    check("to_ins",      32'(ins_out),        32'(exp_ins));
    @(negedge clk);
    check_idle("to_after");
    run_fetch(2, 16'hE0E0, 1'b0, 8'h00, -1, 8'h00, 1'b0);
`else
    // Without the timeout the memory may stall for a long time.
    run_fetch(40, 16'hD00D, 1'b0, 8'h00, -1, 8'h00, 1'b0);
`endif

    // Randomized fetches.
    for (int n = 0; n < 25; n++) begin
      run_fetch($urandom_range(0, 5), 16'($urandom), 1'($urandom_range(0, 1)),
                8'($urandom), -1, 8'h00, 1'b1);
      idle_gap($urandom_range(0, 2));
    end

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
